// File: rtl/fft_r4_bf_stage_pkg.sv
// rtl/fft_r4_bf_stage_pkg.sv - widths, types, rounding helper and twiddle table for the radix-4 stage
// FFT_BF_SAT_EN selects 17-bit saturation with sat reporting; otherwise results wrap.
package fft_pkg;

  localparam int DW     = 17;
  localparam int TW     = 16;
  localparam int LANE_W = 2 * DW;
  localparam int BEAT_W = 4 * LANE_W;
  localparam int LAT    = 3;
  localparam int LANES  = 4;
  localparam int BW     = DW + 2;
  localparam int PW     = 2 * DW;
  localparam int FRAC   = TW - 1;

  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
  } cplx_t;

  typedef struct packed {
    logic                 sat;
    logic signed [DW-1:0] v;
  } rnd_t;

  // (cos, sin)(2*pi*m/16) in Q1.15; m = 5, 7, 8 and 10..15 never occur for a 4x4 grid
  localparam logic [0:15][TW-1:0] TW_COS = {
    16'sd32767, 16'sd30274, 16'sd23170, 16'sd12540,
    16'sd0,     16'sd0,     -16'sd23170, 16'sd0,
    16'sd0,     -16'sd30274, 16'sd0,     16'sd0,
    16'sd0,     16'sd0,     16'sd0,      16'sd0
  };
  localparam logic [0:15][TW-1:0] TW_SIN = {
    16'sd0,     16'sd12540, 16'sd23170, 16'sd30274,
    16'sd32767, 16'sd0,     16'sd23170, 16'sd0,
    16'sd0,     -16'sd12540, 16'sd0,    16'sd0,
    16'sd0,     16'sd0,     16'sd0,     16'sd0
  };

  function automatic rnd_t round_sat(input logic signed [PW-1:0] p);
    rnd_t r;
`ifdef FFT_BF_SAT_EN
    logic signed [PW-1:0] q;
    q     = (p + PW'(1 << (FRAC - 1))) >>> FRAC;
    r.sat = !((&q[PW-1:DW-1]) || !(|q[PW-1:DW-1]));
    r.v   = r.sat ? (q[PW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}})
                  : q[DW-1:0];
`else
    r.sat = 1'b0;
    r.v   = DW'((p + PW'(1 << (FRAC - 1))) >>> FRAC);
`endif
    return r;
  endfunction

endpackage

// File: rtl/fft_r4_bf_stage_if.sv
// rtl/fft_r4_bf_stage_if.sv - beat-in / beat-out bundle of the radix-4 butterfly stage
interface fft_r4_bf_stage_if;
  import fft_pkg::*;

  logic [BEAT_W-1:0] din;
  logic              din_valid;
  logic              sof;
  logic              twiddle_en;
  logic [BEAT_W-1:0] dout;
  logic              dout_valid;
  logic              ovf;

  modport master (
    output din, din_valid, sof, twiddle_en,
    input  dout, dout_valid, ovf
  );

  modport slave (
    input  din, din_valid, sof, twiddle_en,
    output dout, dout_valid, ovf
  );

endinterface

// File: rtl/fft_r4_bf_stage_twiddle_rom.sv
// rtl/fft_r4_bf_stage_twiddle_rom.sv - combinational twiddle lookup m -> (cos, sin)
module fft_twiddle_rom
  import fft_pkg::*;
(
  input  logic [3:0]           m,
  output logic signed [TW-1:0] c,
  output logic signed [TW-1:0] s
);

  assign c = TW_COS[m];
  assign s = TW_SIN[m];

endmodule

// File: rtl/fft_r4_bf_stage.sv
// rtl/fft_r4_bf_stage.sv - 3-stage radix-4 DIF butterfly with per-lane twiddle multiply
// Build with FFT_BF_SAT_EN for saturating outputs and a live ovf flag.
module fft_r4_bf_stage
  import fft_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  fft_r4_bf_stage_if.slave bus
);

  cplx_t                x     [LANES];
  cplx_t                bf    [LANES];
  cplx_t                bf1   [LANES];
  logic signed [BW-1:0] ar, ai, br, bi, cr, ci, dr, di;
  logic [1:0]           cnt;
  logic [1:0]           n_cur;
  logic [3:0]           m_nxt [1:LANES-1];
  logic [3:0]           m1    [1:LANES-1];
  logic                 ten1;
  logic signed [TW-1:0] tw_c  [1:LANES-1];
  logic signed [TW-1:0] tw_s  [1:LANES-1];
  logic signed [PW-1:0] p_re  [LANES];
  logic signed [PW-1:0] p_im  [LANES];
  logic signed [PW-1:0] p2_re [LANES];
  logic signed [PW-1:0] p2_im [LANES];
  rnd_t                 rnd_re [LANES];
  rnd_t                 rnd_im [LANES];
  logic [BEAT_W-1:0]    dout_nxt;
  logic [BEAT_W-1:0]    dout_r;
  logic                 sat_any;
  logic                 ovf_r;
  logic [LAT-1:0]       vld;

  function automatic logic signed [BW-1:0] ext(input logic signed [DW-1:0] v);
    return BW'(v);
  endfunction

  // value scaled by 2^15 so the shared round step returns it unchanged
  function automatic logic signed [PW-1:0] unity(input logic signed [DW-1:0] v);
    return {{(PW-DW-FRAC){v[DW-1]}}, v, {FRAC{1'b0}}};
  endfunction

  for (genvar k = 0; k < LANES; k++) begin : g_unpack
    assign x[k] = bus.din[k*LANE_W +: LANE_W];
  end

  assign ar = ext(x[0].re);
  assign ai = ext(x[0].im);
  assign br = ext(x[1].re);
  assign bi = ext(x[1].im);
  assign cr = ext(x[2].re);
  assign ci = ext(x[2].im);
  assign dr = ext(x[3].re);
  assign di = ext(x[3].im);

  always_comb begin
    bf[0].re = DW'((ar + br + cr + dr) >>> 2);
    bf[0].im = DW'((ai + bi + ci + di) >>> 2);
    bf[1].re = DW'((ar + bi - cr - di) >>> 2);
    bf[1].im = DW'((ai - br - ci + dr) >>> 2);
    bf[2].re = DW'((ar - br + cr - dr) >>> 2);
    bf[2].im = DW'((ai - bi + ci - di) >>> 2);
    bf[3].re = DW'((ar - bi - cr + di) >>> 2);
    bf[3].im = DW'((ai + br - ci - dr) >>> 2);
  end

  // an sof beat always belongs to group 0
  assign n_cur    = bus.sof ? 2'd0 : cnt;
  assign m_nxt[1] = {2'b00, n_cur};
  assign m_nxt[2] = {1'b0, n_cur, 1'b0};
  assign m_nxt[3] = {2'b00, n_cur} + {1'b0, n_cur, 1'b0};

  always_ff @(posedge clk) begin
    for (int k = 0; k < LANES; k++) bf1[k] <= bf[k];
    for (int k = 1; k < LANES; k++) m1[k] <= m_nxt[k];
    ten1 <= bus.twiddle_en;
  end

  for (genvar k = 1; k < LANES; k++) begin : g_rom
    fft_twiddle_rom u_rom (
      .m (m1[k]),
      .c (tw_c[k]),
      .s (tw_s[k])
    );
  end

  always_comb begin
    p_re[0] = unity(bf1[0].re);
    p_im[0] = unity(bf1[0].im);
    for (int k = 1; k < LANES; k++) begin
      if (!ten1 || m1[k] == 4'd0) begin
        p_re[k] = unity(bf1[k].re);
        p_im[k] = unity(bf1[k].im);
      end else begin
        p_re[k] = PW'($signed(bf1[k].re)) * PW'(tw_c[k]) + PW'($signed(bf1[k].im)) * PW'(tw_s[k]);
        p_im[k] = PW'($signed(bf1[k].im)) * PW'(tw_c[k]) - PW'($signed(bf1[k].re)) * PW'(tw_s[k]);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < LANES; k++) begin
      p2_re[k] <= p_re[k];
      p2_im[k] <= p_im[k];
    end
  end

  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      rnd_re[k] = round_sat(p2_re[k]);
      rnd_im[k] = round_sat(p2_im[k]);
    end
  end

  always_comb begin
    dout_nxt = '0;
    sat_any  = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      dout_nxt[k*LANE_W +: LANE_W] = {rnd_re[k].v, rnd_im[k].v};
      sat_any = sat_any | rnd_re[k].sat | rnd_im[k].sat;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout_r <= '0;
      vld    <= '0;
      ovf_r  <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      vld <= {vld[LAT-2:0], bus.din_valid};
      if (vld[LAT-2]) dout_r <= dout_nxt;
      // a saturating output beat wins over a same-cycle sof clear
      if (vld[LAT-2] && sat_any) ovf_r <= 1'b1;
      else if (bus.sof && bus.din_valid) ovf_r <= 1'b0;
      if (bus.din_valid) cnt <= n_cur + 2'd1;
      else if (bus.sof) cnt <= 2'd0;
    end
  end

  assign bus.dout       = dout_r;
  assign bus.dout_valid = vld[LAT-1];
  assign bus.ovf        = ovf_r;

endmodule

// File: tb/tb_fft_r4_bf_stage.sv
// tb/tb_fft_r4_bf_stage.sv - directed vector bench for the radix-4 butterfly stage
module tb_fft_r4_bf_stage;
  import fft_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fft_r4_bf_stage_if bus_if ();

  fft_r4_bf_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  typedef struct {
    logic [BEAT_W-1:0] din;
    logic              ten;
    logic              sof;
    logic [BEAT_W-1:0] exp;
    logic              ovf;
  } vec_t;

  int n_pass  = 0;
  int n_total = 0;

  localparam logic [LANE_W-1:0] Z = '0;
`ifdef FFT_BF_SAT_EN
  localparam int   L1_RE = 65535;
  localparam logic OV    = 1'b1;
`else
  localparam int   L1_RE = -45445;
  localparam logic OV    = 1'b0;
`endif

  function automatic logic [LANE_W-1:0] ln(input int re, input int im);
    return {17'(re), 17'(im)};
  endfunction

  function automatic logic [BEAT_W-1:0] bt(input logic [LANE_W-1:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction

  task automatic chk(input string nm, input logic [BEAT_W-1:0] act, input logic [BEAT_W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    @(posedge clk); #1;
    bus_if.din        = v.din;
    bus_if.twiddle_en = v.ten;
    bus_if.sof        = v.sof;
    bus_if.din_valid  = 1'b1;
    @(posedge clk); #1;
    bus_if.din_valid  = 1'b0;
    bus_if.sof        = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk($sformatf("%s/valid_c%0d", nm, i), BEAT_W'(bus_if.dout_valid), BEAT_W'(i == 3));
    end
    chk({nm, "/dout"}, bus_if.dout, v.exp);
    chk({nm, "/ovf"}, BEAT_W'(bus_if.ovf), BEAT_W'(v.ovf));
    @(negedge clk);
    chk({nm, "/valid_drop"}, BEAT_W'(bus_if.dout_valid), '0);
    chk({nm, "/hold"}, bus_if.dout, v.exp);
  endtask

  initial begin
    vec_t              vecs [11];
    vec_t              vb;
    logic [BEAT_W-1:0] all100, n1, n2, n3, a400, sat_in, sat_out;
    logic [BEAT_W-1:0] seq_exp [5];

    all100  = bt(ln(100, 0), ln(100, 0), ln(100, 0), ln(100, 0));
    n1      = bt(ln(100, 0), ln(92, -38), ln(71, -71), ln(38, -92));
    n2      = bt(ln(100, 0), ln(71, -71), ln(0, -100), ln(-71, -71));
    n3      = bt(ln(100, 0), ln(38, -92), ln(-71, -71), ln(-92, 38));
    a400    = bt(ln(400, 0), Z, Z, Z);
    sat_in  = bt(ln(65535, 65535), ln(-65535, 65535), ln(-65535, -65535), ln(65535, -65535));
    sat_out = bt(Z, ln(L1_RE, 35467), Z, Z);

    vecs[0]  = '{din: bt(ln(100, 0), Z, Z, Z), ten: 1'b0, sof: 1'b1,
                 exp: bt(ln(25, 0), ln(25, 0), ln(25, 0), ln(25, 0)), ovf: 1'b0};
    vecs[1]  = '{din: bt(ln(400, 0), ln(400, 0), ln(400, 0), ln(400, 0)), ten: 1'b0, sof: 1'b1,
                 exp: a400, ovf: 1'b0};
    vecs[2]  = '{din: bt(ln(-3, 5), Z, Z, Z), ten: 1'b0, sof: 1'b0,
                 exp: bt(ln(-1, 1), ln(-1, 1), ln(-1, 1), ln(-1, 1)), ovf: 1'b0};
    vecs[3]  = '{din: '0,     ten: 1'b1, sof: 1'b1, exp: '0,      ovf: 1'b0};
    vecs[4]  = '{din: a400,   ten: 1'b1, sof: 1'b0, exp: n1,      ovf: 1'b0};
    vecs[5]  = '{din: a400,   ten: 1'b1, sof: 1'b0, exp: n2,      ovf: 1'b0};
    vecs[6]  = '{din: a400,   ten: 1'b1, sof: 1'b0, exp: n3,      ovf: 1'b0};
    vecs[7]  = '{din: '0,     ten: 1'b1, sof: 1'b0, exp: '0,      ovf: 1'b0};
    vecs[8]  = '{din: sat_in, ten: 1'b1, sof: 1'b0, exp: sat_out, ovf: OV};
    vecs[9]  = '{din: a400,   ten: 1'b0, sof: 1'b0, exp: all100,  ovf: OV};
    vecs[10] = '{din: a400,   ten: 1'b1, sof: 1'b1, exp: all100,  ovf: 1'b0};

    rst_n             = 1'b0;
    bus_if.din        = '0;
    bus_if.din_valid  = 1'b0;
    bus_if.sof        = 1'b0;
    bus_if.twiddle_en = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset/dout", bus_if.dout, '0);
    chk("reset/valid", BEAT_W'(bus_if.dout_valid), '0);
    chk("reset/ovf", BEAT_W'(bus_if.ovf), '0);

    for (int i = 0; i < 11; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // re-arm ovf, then a back-to-back frame whose first beat carries sof
    run_vec(vecs[3], "rearm_sof");
    run_vec(vecs[8], "rearm_sat");
    seq_exp[0] = all100;
    seq_exp[1] = n1;
    seq_exp[2] = n2;
    seq_exp[3] = n3;
    seq_exp[4] = all100;
    for (int j = 0; j < 10; j++) begin
      @(posedge clk); #1;
      if (j < 5) begin
        bus_if.din        = a400;
        bus_if.twiddle_en = 1'b1;
        bus_if.sof        = (j == 0 || j == 4);
        bus_if.din_valid  = 1'b1;
      end else begin
        bus_if.din_valid  = 1'b0;
        bus_if.sof        = 1'b0;
      end
      @(negedge clk);
      if (j == 0) chk("b2b/ovf_before_sof", BEAT_W'(bus_if.ovf), BEAT_W'(OV));
      if (j == 1) chk("b2b/ovf_cleared", BEAT_W'(bus_if.ovf), '0);
      chk($sformatf("b2b/valid%0d", j), BEAT_W'(bus_if.dout_valid), BEAT_W'(j >= 3 && j <= 7));
      if (j >= 3 && j <= 7) chk($sformatf("b2b/dout%0d", j), bus_if.dout, seq_exp[j-3]);
    end

    // reset with two beats in flight
    @(posedge clk); #1;
    bus_if.din        = a400;
    bus_if.twiddle_en = 1'b1;
    bus_if.sof        = 1'b1;
    bus_if.din_valid  = 1'b1;
    @(posedge clk); #1;
    bus_if.sof        = 1'b0;
    @(posedge clk); #1;
    bus_if.din_valid  = 1'b0;
    rst_n             = 1'b0;
    @(posedge clk); #1;
    rst_n             = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("rst_flight/valid%0d", i), BEAT_W'(bus_if.dout_valid), '0);
      chk($sformatf("rst_flight/dout%0d", i), bus_if.dout, '0);
    end
    chk("rst_flight/ovf", BEAT_W'(bus_if.ovf), '0);
    vb = '{din: a400, ten: 1'b1, sof: 1'b0, exp: all100, ovf: 1'b0};
    run_vec(vb, "cnt_after_reset");

    // sof without din_valid returns the group counter to 0
    @(posedge clk); #1;
    bus_if.sof       = 1'b1;
    bus_if.din_valid = 1'b0;
    run_vec(vb, "cnt_after_bare_sof");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
